// File: rtl/ccip_c1tx_arbiter.sv
// CCI-P C1 Tx (write) channel arbiter.
// Round-robin sharing of the write channel between NUM_REQ requesters, with
// almost-full back-pressure, an outstanding-write cap fed by C1 Rx write
// responses, and WrFence sequencing (drain, issue, wait for fence response).

package ccip_c1tx_pkg;

   localparam int CCIP_DATA_WIDTH = 512;

   // C1 Tx request types.
   localparam logic [3:0] REQ_WRLINE_I = 4'h1;
   localparam logic [3:0] REQ_WRLINE_M = 4'h2;
   localparam logic [3:0] REQ_WRPUSH_I = 4'h3;
   localparam logic [3:0] REQ_WRFENCE  = 4'h4;

   typedef struct packed {
      logic [1:0]  vc;
      logic [3:0]  reqtype;
      logic [15:0] mdata;
      logic [41:0] addr;
   } TxHdr_t;

   function automatic logic is_wrline(input logic [3:0] reqtype);
      return (reqtype == REQ_WRLINE_I) || (reqtype == REQ_WRLINE_M);
   endfunction

endpackage

module ccip_c1tx_arbiter
   import ccip_c1tx_pkg::*;
#(
   parameter int NUM_REQ         = 4,
   parameter int MAX_OUTSTANDING = 64,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                       clk,
   input  logic                       SoftReset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  TxHdr_t                     req_hdr  [NUM_REQ],
   input  logic [CCIP_DATA_WIDTH-1:0] req_data [NUM_REQ],
   output logic [NUM_REQ-1:0]         req_ready,
   output TxHdr_t                     C1TxHdr,
   output logic [CCIP_DATA_WIDTH-1:0] C1TxData,
   output logic                       C1TxWrValid,
   input  logic                       C1TxAlmFull,
   input  logic                       C1RxWrValid,
   input  logic                       C1RxFenceRspValid,
   output logic [CNT_W-1:0]           outstanding,
   output logic                       fence_busy,
   output logic                       err_underflow
);

   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      ARB,
      DRAIN,
      FENCE_WAIT
   } t_state;

   t_state                     state_q, state_d;
   logic [PTR_W-1:0]           ptr_q, ptr_d;
   logic [PTR_W-1:0]           owner_q, owner_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       err_q, err_d;
   logic                       valid_q, valid_d;
   TxHdr_t                     hdr_q, hdr_d;
   logic [CCIP_DATA_WIDTH-1:0] data_q, data_d;

   logic                       can_issue;
   logic                       pending_wr;
   logic [CNT_W:0]             eff_cnt;
   logic                       wr_room;
   logic                       drained;
   logic                       win_found;
   logic [PTR_W-1:0]           win_idx;
   logic [PTR_W-1:0]           cand;
   logic [3:0]                 win_type;
   logic                       grant;
   logic [PTR_W-1:0]           grant_idx;

   // A write sitting in the output register has not been counted yet, so it
   // is added here before the cap and drain decisions are taken.
   assign can_issue  = !C1TxAlmFull && !SoftReset;
   assign pending_wr = valid_q && is_wrline(hdr_q.reqtype);
   assign eff_cnt    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, pending_wr};
   assign wr_room    = eff_cnt < (CNT_W+1)'(MAX_OUTSTANDING);
   assign drained    = (eff_cnt == '0);

   // Round-robin search: first valid requester starting at the pointer.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_type = req_hdr[win_idx].reqtype;

   // Grant decision, fence sequencing and next-state for all registers.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      grant     = 1'b0;
      grant_idx = win_idx;
      req_ready = '0;

      unique case (state_q)
         ARB: begin
            if (win_found) begin
               if (win_type == REQ_WRFENCE) begin
                  if (drained && can_issue) begin
                     grant   = 1'b1;
                     state_d = FENCE_WAIT;
                  end else begin
                     owner_d = win_idx;
                     state_d = DRAIN;
                  end
               end else if (is_wrline(win_type)) begin
                  grant = can_issue && wr_room;
               end else begin
                  grant = can_issue;
               end
            end
         end
         DRAIN: begin
            // The owner gave up its fence: nothing left to sequence.
            if (!req_valid[owner_q]) begin
               state_d = ARB;
            end else if (drained && can_issue) begin
               grant     = 1'b1;
               grant_idx = owner_q;
               state_d   = FENCE_WAIT;
            end
         end
         FENCE_WAIT: begin
            if (C1RxFenceRspValid) begin
               state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase

      if (grant) begin
         req_ready[grant_idx] = 1'b1;
         ptr_d = PTR_W'((int'(grant_idx) + 1) % NUM_REQ);
      end

      // Output register: valid only on a grant, header/data hold otherwise.
      valid_d = grant;
      hdr_d   = grant ? req_hdr[grant_idx]  : hdr_q;
      data_d  = grant ? req_data[grant_idx] : data_q;

      // Outstanding counter: issue and response in one cycle cancel out;
      // a lone response at zero saturates and flags the underflow.
      cnt_d = cnt_q;
      err_d = err_q;
      if (pending_wr && !C1RxWrValid) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!pending_wr && C1RxWrValid) begin
         if (cnt_q == '0) begin
            err_d = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end
   end

   // State, pointer, counter and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (SoftReset) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         state_q <= ARB;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         hdr_q   <= '0;
         // NOTE: the wide data register is reset on purpose: C1TxData must read 0 after reset.
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         hdr_q   <= hdr_d;
         data_q  <= data_d;
      end
   end

   assign C1TxHdr       = hdr_q;
   assign C1TxData      = data_q;
   assign C1TxWrValid   = valid_q;
   assign outstanding   = cnt_q;
   assign fence_busy    = (state_q != ARB);
   assign err_underflow = err_q;

endmodule

// File: tb/tb_ccip_c1tx_arbiter.sv
// Scoreboard bench for ccip_c1tx_arbiter: stimulus pushes expected issues in
// hand-derived arbitration order, a monitor pops and compares on C1TxWrValid,
// and a driver process plays requesters and the write-response channel.

module tb_ccip_c1tx_arbiter;
   import ccip_c1tx_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int MAX_OUT = 64;
   localparam int CNT_W   = $clog2(MAX_OUT) + 1;
   localparam int RSP_LAT = 10;

   logic                       clk = 1'b0;
   logic                       SoftReset = 1'b1;
   logic [NUM_REQ-1:0]         req_valid = '0;
   TxHdr_t                     req_hdr  [NUM_REQ];
   logic [CCIP_DATA_WIDTH-1:0] req_data [NUM_REQ];
   logic [NUM_REQ-1:0]         req_ready;
   TxHdr_t                     C1TxHdr;
   logic [CCIP_DATA_WIDTH-1:0] C1TxData;
   logic                       C1TxWrValid;
   logic                       C1TxAlmFull = 1'b0;
   logic                       C1RxWrValid = 1'b0;
   logic                       C1RxFenceRspValid = 1'b0;
   logic [CNT_W-1:0]           outstanding;
   logic                       fence_busy;
   logic                       err_underflow;

   always #5 clk = ~clk;

   ccip_c1tx_arbiter #(
      .NUM_REQ         (NUM_REQ),
      .MAX_OUTSTANDING (MAX_OUT),
      .CNT_W           (CNT_W)
   ) dut (
      .clk               (clk),
      .SoftReset         (SoftReset),
      .req_valid         (req_valid),
      .req_hdr           (req_hdr),
      .req_data          (req_data),
      .req_ready         (req_ready),
      .C1TxHdr           (C1TxHdr),
      .C1TxData          (C1TxData),
      .C1TxWrValid       (C1TxWrValid),
      .C1TxAlmFull       (C1TxAlmFull),
      .C1RxWrValid       (C1RxWrValid),
      .C1RxFenceRspValid (C1RxFenceRspValid),
      .outstanding       (outstanding),
      .fence_busy        (fence_busy),
      .err_underflow     (err_underflow)
   );

   typedef struct {
      TxHdr_t                     hdr;
      logic [CCIP_DATA_WIDTH-1:0] data;
   } t_exp;

   t_exp   exp_q [$];
   TxHdr_t pend  [NUM_REQ][$];
   int     seq_stim [NUM_REQ];
   int     seq_exp  [NUM_REQ];
   int     n_checks = 0;
   int     n_errors = 0;
   bit     auto_rsp = 1'b1;
   int     manual_pulses = 0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic TxHdr_t mk_hdr(input int r, input int s, input logic [3:0] t);
      TxHdr_t h;
      h.vc      = 2'b01;
      h.reqtype = t;
      h.mdata   = {4'(r), 12'(s)};
      h.addr    = 42'(32'h1000_0000 + r * 4096 + s);
      return h;
   endfunction

   function automatic logic [CCIP_DATA_WIDTH-1:0] data_of(input TxHdr_t h);
      return {32{h.mdata}};
   endfunction

   task automatic add_req(input int r, input logic [3:0] t);
      pend[r].push_back(mk_hdr(r, seq_stim[r], t));
      seq_stim[r]++;
   endtask

   task automatic expect_req(input int r, input logic [3:0] t);
      t_exp e;
      e.hdr  = mk_hdr(r, seq_exp[r], t);
      e.data = data_of(e.hdr);
      exp_q.push_back(e);
      seq_exp[r]++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         sample();
      end
   endtask

   task automatic run_count(input int n, output int cnt);
      cnt = 0;
      repeat (n) begin
         step();
         sample();
         if (C1TxWrValid) cnt++;
      end
   endtask

   // Monitor: every issue on the channel is matched against the scoreboard.
   initial begin
      t_exp e;
      forever begin
         @(negedge clk);
         if (C1TxWrValid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_unexpected: issue mdata=%0h with nothing expected (t=%0t)",
                        C1TxHdr.mdata, $time);
            end else begin
               e = exp_q.pop_front();
               check("sb_hdr", C1TxHdr, e.hdr);
               check("sb_data", 64'(C1TxData == e.data), 64'd1);
            end
         end
         if (|req_ready) begin
            check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
            check("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
         end
      end
   end

   // Driver: requester agents (hold a request until granted) and the
   // write-response channel (auto replies after RSP_LAT, or manual pulses).
   initial begin
      logic [NUM_REQ-1:0] grant_seen;
      int cyc = 0;
      int manual_done = 0;
      int rsp_due [$];
      for (int i = 0; i < NUM_REQ; i++) begin
         req_hdr[i]  = '0;
         req_data[i] = '0;
      end
      forever begin
         @(negedge clk);
         grant_seen = req_ready & req_valid;
         @(posedge clk);
         #2;
         cyc++;
         C1RxWrValid = 1'b0;
         if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
            void'(rsp_due.pop_front());
            C1RxWrValid = 1'b1;
         end else if (manual_done < manual_pulses) begin
            manual_done++;
            C1RxWrValid = 1'b1;
         end
         if (C1TxWrValid && auto_rsp && is_wrline(C1TxHdr.reqtype))
            rsp_due.push_back(cyc + RSP_LAT);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_seen[i] && pend[i].size() > 0) void'(pend[i].pop_front());
            req_valid[i] = (pend[i].size() != 0);
            req_hdr[i]   = req_valid[i] ? pend[i][0] : '0;
            req_data[i]  = data_of(req_hdr[i]);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Stimulus and point checks.
   initial begin
      int cnt;
      int order [4];
      order = '{2, 3, 0, 1};
      for (int i = 0; i < NUM_REQ; i++) begin
         seq_stim[i] = 0;
         seq_exp[i]  = 0;
      end

      // Reset state.
      step(); step(); sample();
      check("rst_valid", 64'(C1TxWrValid), 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_fence_busy", 64'(fence_busy), 64'd0);
      check("rst_err", 64'(err_underflow), 64'd0);
      check("rst_hdr", C1TxHdr, 64'd0);
      check("rst_data", 64'(C1TxData == '0), 64'd1);
      step(); SoftReset = 1'b0;

      // Streaming: all four requesters, responses after RSP_LAT cycles.
      step();
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            add_req(i, REQ_WRLINE_I);
            expect_req(i, REQ_WRLINE_I);
         end
      end
      cnt = 0;
      for (int k = 1; k <= 32; k++) begin
         step(); sample();
         if (C1TxWrValid) cnt++;
         if (k == 20) check("t1_outstanding_steady", 64'(outstanding), 64'd10);
      end
      check("t1_valid_every_cycle", 64'(cnt), 64'd32);
      idle(15);
      check("t1_drained", 64'(outstanding), 64'd0);
      check("t1_sb_empty", 64'(exp_q.size()), 64'd0);

      // Pointer wrap: req 2 alone, then req 1 and 3.
      step();
      add_req(2, REQ_WRLINE_I); expect_req(2, REQ_WRLINE_I);
      sample();
      check("t2_grant_2", 64'(req_ready), 64'b0100);
      step();
      add_req(1, REQ_WRLINE_I); add_req(3, REQ_WRLINE_I);
      expect_req(3, REQ_WRLINE_I); expect_req(1, REQ_WRLINE_I);
      sample();
      check("t2_grant_3", 64'(req_ready), 64'b1000);
      step(); sample();
      check("t2_grant_1", 64'(req_ready), 64'b0010);
      idle(15);
      check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

      // AlmFull for 5 cycles during streaming.
      step();
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < 4; j++) begin
            add_req(order[j], REQ_WRLINE_I);
            expect_req(order[j], REQ_WRLINE_I);
         end
      end
      idle(4);
      step(); C1TxAlmFull = 1'b1; sample();
      check("t3_last_issue", 64'(C1TxWrValid), 64'd1);
      check("t3_no_grant", 64'(req_ready), 64'd0);
      for (int k = 1; k <= 4; k++) begin
         step(); sample();
         check("t3_stalled", 64'(C1TxWrValid), 64'd0);
      end
      step(); C1TxAlmFull = 1'b0; sample();
      check("t3_stalled_last", 64'(C1TxWrValid), 64'd0);
      step(); sample();
      check("t3_resumed", 64'(C1TxWrValid), 64'd1);
      idle(40);
      check("t3_drained", 64'(outstanding), 64'd0);
      check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

      // Outstanding cap at 64 with responses withheld.
      auto_rsp = 1'b0;
      step();
      for (int r = 0; r < 17; r++) begin
         for (int j = 0; j < 4; j++) begin
            add_req(order[j], REQ_WRLINE_I);
            expect_req(order[j], REQ_WRLINE_I);
         end
      end
      idle(75);
      check("t4_cap", 64'(outstanding), 64'd64);
      check("t4_left", 64'(exp_q.size()), 64'd4);
      run_count(5, cnt);
      check("t4_no_issue_at_cap", 64'(cnt), 64'd0);
      step(); manual_pulses++; sample();
      check("t4_cap_hold", 64'(req_ready), 64'd0);
      step(); sample();
      check("t4_after_rsp", 64'(outstanding), 64'd63);
      check("t4_one_grant", 64'(req_ready), 64'b0100);
      step(); sample();
      check("t4_issue", 64'(C1TxWrValid), 64'd1);
      step(); sample();
      check("t4_recapped", 64'(outstanding), 64'd64);
      check("t4_no_second", 64'(C1TxWrValid), 64'd0);
      check("t4_left_after", 64'(exp_q.size()), 64'd3);
      auto_rsp = 1'b1;
      manual_pulses += 64;
      idle(90);
      check("t4_drained", 64'(outstanding), 64'd0);
      check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

      // WrFence with 3 writes outstanding.
      auto_rsp = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         add_req(0, REQ_WRLINE_I);
         expect_req(0, REQ_WRLINE_I);
      end
      idle(6);
      check("t5_outstanding3", 64'(outstanding), 64'd3);
      step();
      add_req(1, REQ_WRFENCE); add_req(2, REQ_WRLINE_I); add_req(3, REQ_WRLINE_I);
      expect_req(1, REQ_WRFENCE); expect_req(2, REQ_WRLINE_I); expect_req(3, REQ_WRLINE_I);
      sample();
      check("t5_no_grant_arb", 64'(req_ready), 64'd0);
      step(); sample();
      check("t5_fence_busy", 64'(fence_busy), 64'd1);
      run_count(4, cnt);
      check("t5_drain_blocks", 64'(cnt), 64'd0);
      step(); manual_pulses += 3; sample();
      step(); sample();
      step(); sample();
      check("t5_out1", 64'(outstanding), 64'd1);
      check("t5_out1_ready", 64'(req_ready), 64'd0);
      step(); sample();
      check("t5_out0", 64'(outstanding), 64'd0);
      check("t5_fence_grant", 64'(req_ready), 64'b0010);
      step(); sample();
      check("t5_fence_issue", 64'(C1TxWrValid), 64'd1);
      check("t5_fence_type", 64'(C1TxHdr.reqtype), 64'(REQ_WRFENCE));
      run_count(5, cnt);
      check("t5_wait_blocks", 64'(cnt), 64'd0);
      check("t5_wait_busy", 64'(fence_busy), 64'd1);
      step(); C1RxFenceRspValid = 1'b1; auto_rsp = 1'b1; sample();
      check("t5_rsp_cycle_no_grant", 64'(req_ready), 64'd0);
      step(); C1RxFenceRspValid = 1'b0; sample();
      check("t5_idle_busy", 64'(fence_busy), 64'd0);
      check("t5_resume_grant", 64'(req_ready), 64'b0100);
      idle(20);
      check("t5_drained", 64'(outstanding), 64'd0);
      check("t5_sb_empty", 64'(exp_q.size()), 64'd0);
      check("t5_no_underflow", 64'(err_underflow), 64'd0);

      // Underflow, then SoftReset while waiting on a fence.
      step(); manual_pulses++; sample();
      step(); sample();
      check("t6_saturate", 64'(outstanding), 64'd0);
      check("t6_err_set", 64'(err_underflow), 64'd1);
      step();
      add_req(0, REQ_WRFENCE); add_req(1, REQ_WRLINE_I);
      expect_req(0, REQ_WRFENCE);
      sample();
      check("t6_fence_grant", 64'(req_ready), 64'b0001);
      idle(3);
      check("t6_wait_busy", 64'(fence_busy), 64'd1);
      check("t6_err_sticky", 64'(err_underflow), 64'd1);
      check("t6_wait_no_grant", 64'(req_ready), 64'd0);
      step(); SoftReset = 1'b1; sample();
      check("t6_rst_no_grant", 64'(req_ready), 64'd0);
      step(); SoftReset = 1'b0; expect_req(1, REQ_WRLINE_I); sample();
      check("t6_rst_busy", 64'(fence_busy), 64'd0);
      check("t6_rst_err", 64'(err_underflow), 64'd0);
      check("t6_rst_valid", 64'(C1TxWrValid), 64'd0);
      check("t6_rst_hdr", C1TxHdr, 64'd0);
      check("t6_arb_grant", 64'(req_ready), 64'b0010);
      step(); sample();
      check("t6_arb_issue", 64'(C1TxWrValid), 64'd1);
      idle(15);
      check("t6_drained", 64'(outstanding), 64'd0);
      check("final_sb_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ccip_c1tx_arbiter.md
Name: ccip_c1tx_arbiter

Overview:
- Shares the CCI-P C1 Tx (write) channel between NUM_REQ AFU-side requesters using round-robin arbitration.
- Honours C1TxAlmFull and caps outstanding writes with a counter driven by C1 Rx write responses.
- Sequences WrFence requests: drains outstanding writes, issues the fence, then holds until the fence response returns.
- Sits between AFU sub-engines and the ASE CCI-P interface; its output feeds the channel the transaction logger watches.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_OUTSTANDING, 64, maximum writes in flight (power of two).
- CNT_W, $clog2(MAX_OUTSTANDING)+1, width of the outstanding counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- SoftReset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_hdr  in  NUM_REQ x TxHdr_t  per-requester header (vc, reqtype, mdata, addr).
- req_data  in  NUM_REQ x CCIP_DATA_WIDTH  per-requester write data.
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational.
- C1TxHdr  out  TxHdr_t  registered header to the channel.
- C1TxData  out  CCIP_DATA_WIDTH  registered data.
- C1TxWrValid  out  1  registered valid.
- C1TxAlmFull  in  1  channel almost-full.
- C1RxWrValid  in  1  write response (one per WrLine_I/WrLine_M).
- C1RxFenceRspValid  in  1  fence response.
- outstanding  out  CNT_W  writes in flight.
- fence_busy  out  1  high in DRAIN or FENCE_WAIT.
- err_underflow  out  1  sticky: response received while outstanding==0.

Behaviour:
- Reset, sampled at posedge with SoftReset=1:
  - All outputs 0; C1TxHdr/C1TxData 0.
  - RR pointer = 0; outstanding = 0; state = ARB; err_underflow cleared.
  - Reset asserted mid-fence returns to ARB immediately. Any in-flight register is dropped (C1TxWrValid=0 next cycle).
- States: ARB, DRAIN, FENCE_WAIT.
- can_issue = !C1TxAlmFull && !SoftReset.
- ARB:
  - Winner = first i with req_valid[i], searching from ptr to ptr+NUM_REQ-1 modulo NUM_REQ.
  - For WrLine_I/WrLine_M: grant only if can_issue && outstanding < MAX_OUTSTANDING.
  - On grant: req_ready[winner]=1 that cycle; hdr/data registered; C1TxWrValid=1 next cycle (latency 1); ptr = winner+1 mod NUM_REQ.
  - For WrFence: if outstanding==0 && can_issue, grant and issue as a normal request, then go to FENCE_WAIT. Otherwise go to DRAIN without granting.
  - Any other reqtype is granted and issued unchanged and does not touch the counter.
- DRAIN:
  - No grants; the fence owner index is latched.
  - When outstanding==0 && can_issue: grant the latched owner, issue the fence, go to FENCE_WAIT.
  - The owner must hold req_valid/req_hdr stable; if it drops req_valid, return to ARB.
- FENCE_WAIT:
  - No grants.
  - On C1RxFenceRspValid: go to ARB. The fence response does not change outstanding.
- Counter:
  - +1 on an issued write (the cycle C1TxWrValid=1 with a WrLine reqtype); -1 on C1RxWrValid.
  - Both in the same cycle: net unchanged.
  - Decrement at 0: saturate at 0 and set err_underflow.
  - Never exceeds MAX_OUTSTANDING: grants are gated on outstanding < MAX, counting the issue pending in the output register.
- AlmFull: C1TxAlmFull=1 in cycle t means no grant in t, so C1TxWrValid=0 in t+1. A write already registered in t still issues.
- At most one req_ready bit is high per cycle. req_ready is never high when req_valid is low for that bit.
- C1TxWrValid=0 on every cycle without a grant; hdr/data hold their last value.

Test Plan:
- All 4 requesters valid continuously with WrLine_I, AlmFull=0, responses returned 10 cycles after issue → grants cycle 0,1,2,3,0,...; C1TxWrValid high every cycle from cycle 1; outstanding settles at 10.
- Only req 2 valid, then req 1 and req 3 both assert → after granting 2, next grant goes to 3, then 1 (pointer wraps past 3 to 0).
- AlmFull asserted for 5 cycles during streaming → exactly one further C1TxWrValid, then 0 for 5 cycles; resumes 1 cycle after AlmFull drops; no request lost or duplicated (check mdata sequence).
- Withhold responses, issue 64 writes → outstanding=64, no grants; one C1RxWrValid → outstanding=63, one grant next cycle.
- Req 1 issues WrFence with outstanding=3 → fence_busy=1; fence issued the cycle after outstanding reaches 0; other valid requests get no grant until C1RxFenceRspValid; then ARB resumes.
- C1RxWrValid with outstanding=0 → outstanding stays 0, err_underflow=1 until SoftReset; SoftReset during FENCE_WAIT → state ARB, outputs 0 next cycle.
